regfile_param: RTL
==================

// Module: regfile_param
// PURPOSE
//   Parametrised register file: WIDTH x DEPTH storage, one synchronous write port, two registered read ports.
//   Successor to the single-bit / 32-bit enable-register primitives; it generalises them in width and depth.
//   Register 0 is hard-wired to zero, selectable by parameter.
//   Sits between decode (addresses) and execute (operands) in the CPU datapath.
// PARAMETERS
//   WIDTH     32   data width of each entry, >= 1
//   DEPTH     32   number of entries, >= 2
//   AW        5    address width; must satisfy 2**AW >= DEPTH
//   ZERO_REG  1    1: entry 0 reads 0 and ignores writes; 0: entry 0 is ordinary storage
// PORTS
//   clk        in   1      clock, all state updates on posedge
//   rst_n      in   1      asynchronous active-low reset
//   wr_en      in   1      write enable, sampled on posedge clk
//   wr_addr    in   AW     write address
//   wr_data    in   WIDTH  write data
//   rd_addr_a  in   AW     read address, port A
//   rd_addr_b  in   AW     read address, port B
//   rd_data_a  out  WIDTH  registered read data, port A
//   rd_data_b  out  WIDTH  registered read data, port B
// BEHAVIOUR
//   Reset
//   - rst_n low clears, immediately and without waiting for clk, all DEPTH entries, rd_data_a and rd_data_b to 0.
//   - While rst_n is low, writes are ignored.
//   - First clk edge after rst_n rises behaves normally.
//   - Reset asserted mid-operation discards any write in flight. No partial update survives.
//   Write
//   - At posedge clk with wr_en=1 and wr_addr<DEPTH: mem[wr_addr] <= wr_data.
//   - With wr_en=0, storage holds.
//   - wr_addr >= DEPTH: the write is dropped, with no aliasing or wrap-around.
//   - ZERO_REG=1 and wr_addr==0: the write is dropped.
//   Read
//   - Latency is 1 cycle. At posedge k, rd_data_x <= value(rd_addr_x sampled at k).
//   - The output holds until the next edge.
//   - Read ports are independent; both may address the same entry.
//   - rd_addr_x >= DEPTH reads 0.
//   - ZERO_REG=1 and rd_addr_x==0 reads 0.
//   Same-edge read/write collision (rd_addr_x==wr_addr, wr_en=1, write legal)
//   - Resolved as described under CONFIGURATION.
//   - Zero-reg and out-of-range writes are never forwarded.
//   - No state machine; state is storage plus two output registers.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined
//   - Write-first: on collision, rd_data_x at that edge takes wr_data.
//   - A value written at edge k is therefore visible at rd_data at edge k, the same edge it is written.
//   REGFILE_BYPASS_EN undefined
//   - Read-first: on collision, rd_data_x takes the old mem contents.
//   - The new value is visible only from the next edge that reads that address.
// TESTING
//   (defaults WIDTH=32 DEPTH=32 ZERO_REG=1)
//   1. Reset
//      - Write 0xDEADBEEF to addr 5, then pulse rst_n low between edges.
//      - Required: rd_data_a/b drop to 0 with no clk edge.
//      - Required: a subsequent read of addr 5 returns 0.
//   2. Write/read
//      - Write 0x12345678 to addr 3 and 0xA5A5A5A5 to addr 31.
//      - Read A=3, B=31.
//      - Required: one edge later, rd_data_a=0x12345678 and rd_data_b=0xA5A5A5A5.
//   3. Zero register
//      - Write 0xFFFFFFFF to addr 0, then read A=B=0.
//      - Required: both read 0.
//      - Repeat with ZERO_REG=0: required 0xFFFFFFFF on both.
//   4. Collision
//      - addr 7 holds 0x11. At the same edge: write 0x22 to addr 7, read A=7.
//      - With REGFILE_BYPASS_EN: rd_data_a=0x22.
//      - Without it: rd_data_a=0x11, then 0x22 on the next edge.
//   5. Disabled write
//      - wr_en=0 with wr_addr=9, wr_data=0x55.
//      - Required: addr 9 still reads its prior value.
//   6. Out of range (DEPTH=24)
//      - Write 0x77 to addr 25.
//      - Required: addr 25 reads 0.
//      - Required: addr 1 (25 mod 24) is unchanged.

Source files
------------

// File: rtl/regfile_param.sv
// WIDTH x DEPTH register file: one synchronous write port, two registered read ports.
// Define REGFILE_BYPASS_EN for write-first collisions; default build is read-first.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_a_q, rd_a_d;
  logic [WIDTH-1:0] rd_b_q, rd_b_d;
  logic             wr_ok;

  // Legal entry: in range and not the hard-wired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok = wr_en && addr_ok(wr_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_a_d = '0;
    if (addr_ok(rd_addr_a)) begin
      rd_a_d = mem_q[rd_addr_a];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr_a)) begin
        rd_a_d = wr_data;
      end
`endif
    end
  end

  always_comb begin
    rd_b_d = '0;
    if (addr_ok(rd_addr_b)) begin
      rd_b_d = mem_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr_b)) begin
        rd_b_d = wr_data;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;

endmodule
